// File: rtl/reg_flops_if.sv
// Bus bundle for reg_flops: channel E (load-enable register) and channel S (start-gated register).
// The master side drives gates and next values; the slave side returns the registered values.
interface reg_flops_if #(
   parameter int W_EN = 2,
   parameter int W_ST = 32
);
   logic            en;
   logic [W_EN-1:0] d_en;
   logic [W_EN-1:0] q_en;
   logic            start;
   logic [W_ST-1:0] d_st;
   logic [W_ST-1:0] q_st;

   modport master (
      output en,
      output d_en,
      input  q_en,
      output start,
      output d_st,
      input  q_st
   );

   modport slave (
      input  en,
      input  d_en,
      output q_en,
      input  start,
      input  d_st,
      output q_st
   );
endinterface

// File: rtl/reg_flops.sv
// Two independent async-reset registers sharing clk/reset: channel E (flags, load enable)
// and channel S (program counter, frozen at 0 until start is raised).
module reg_flops #(
   parameter int W_EN = 2,
   parameter int W_ST = 32
) (
   input  logic      clk,
   input  logic      reset,
   reg_flops_if.slave bus
);

   logic [W_EN-1:0] q_en_r;
   logic [W_ST-1:0] q_st_r;

   // Gates are data-path muxes on the flop input; the clock is never gated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_en_r <= '0;
      end else if (bus.en) begin
         q_en_r <= bus.d_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_st_r <= '0;
      end else if (bus.start) begin
         q_st_r <= bus.d_st;
      end
   end

   assign bus.q_en = q_en_r;
   assign bus.q_st = q_st_r;

endmodule

// File: tb/tb_reg_flops.sv
// Self-checking bench for reg_flops: directed scenarios plus randomized traffic against
// a plain behavioural model of the two gated registers and a sticky 1-bit flag instance.
module tb_reg_flops;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_flops_if #(.W_EN(2), .W_ST(32)) bus  ();
   reg_flops_if #(.W_EN(1), .W_ST(8))  sbus ();

   reg_flops #(.W_EN(2), .W_ST(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   reg_flops #(.W_EN(1), .W_ST(8)) u_flag (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [1:0]  m_en;
   logic [31:0] m_st;
   logic        m_flag;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q_en"}, 64'(bus.q_en), 64'(m_en));
      chk({tag, ".q_st"}, 64'(bus.q_st), 64'(m_st));
      chk({tag, ".flag"}, 64'(sbus.q_en), 64'(m_flag));
      chk({tag, ".flag_st"}, 64'(sbus.q_st), 64'd0);
   endtask

   // One rising edge; the model applies reset > gate > hold to the inputs seen at that edge.
   task automatic step();
      @(posedge clk);
      if (reset) begin
         m_en = '0; m_st = '0; m_flag = 1'b0;
      end else begin
         if (bus.en)    m_en   = bus.d_en;
         if (bus.start) m_st   = bus.d_st;
         if (sbus.en)   m_flag = sbus.d_en;
      end
      #1;
   endtask

   // Async reset pulse strictly between edges; outputs must clear with no clock.
   task automatic pulse_reset(input string tag);
      #1;
      reset = 1'b1;
      m_en = '0; m_st = '0; m_flag = 1'b0;
      #1;
      check_all({tag, ".during"});
      reset = 1'b0;
      #1;
      check_all({tag, ".after"});
   endtask

   initial begin
      reset      = 1'b1;
      bus.en     = 1'b0; bus.d_en  = '0;
      bus.start  = 1'b0; bus.d_st  = '0;
      sbus.en    = 1'b0; sbus.d_en = 1'b1;
      sbus.start = 1'b0; sbus.d_st = '0;
      m_en = '0; m_st = '0; m_flag = 1'b0;
      #2;
      check_all("por");
      step();
      step();
      reset = 1'b0;
      #1;
      check_all("por_release");

      // reset pulse between edges after loading non-zero values
      bus.d_en = 2'b11; bus.en = 1'b1; bus.d_st = 32'hDEAD_BEEF; bus.start = 1'b1;
      step();
      check_all("load_pre_rst");
      pulse_reset("rst_pulse");
      bus.en = 1'b0; bus.start = 1'b0;
      step();
      check_all("rst_hold_until_gate");
      bus.en = 1'b1; bus.start = 1'b1;
      step();
      check_all("rst_first_gate");

      // enable hold
      bus.en = 1'b1; bus.d_en = 2'b10; bus.start = 1'b0;
      step();
      check_all("en_load");
      bus.en = 1'b0; bus.d_en = 2'b01;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("en_hold");
      end

      // start gate with PC-style feedback
      pulse_reset("pc_rst");
      bus.start = 1'b0; bus.d_st = 32'd4;
      for (int i = 0; i < 5; i++) step();
      check_all("st_frozen");
      chk("st_frozen_zero", 64'(bus.q_st), 64'd0);
      bus.start = 1'b1;
      step();
      chk("pc_first", 64'(bus.q_st), 64'd4);
      for (int i = 0; i < 3; i++) begin
         bus.d_st = m_st + 32'd4;
         step();
         chk("pc_incr", 64'(bus.q_st), 64'(32'd8 + 32'(4 * i)));
      end

      // sticky flag: one-cycle enable pulse, then hold for 10 clocks
      bus.start = 1'b0;
      sbus.en = 1'b1;
      step();
      sbus.en = 1'b0;
      chk("flag_set", 64'(sbus.q_en), 64'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         check_all("flag_hold");
      end
      pulse_reset("flag_rst");
      chk("flag_cleared", 64'(sbus.q_en), 64'd0);

      // reset priority across two edges with both gates high
      bus.en = 1'b1; bus.d_en = 2'b11; bus.start = 1'b1; bus.d_st = 32'h1234_5678;
      sbus.en = 1'b1;
      step();
      check_all("prio_pre");
      #1 reset = 1'b1;
      m_en = '0; m_st = '0; m_flag = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check_all("prio_rst");
      end
      reset = 1'b0; sbus.en = 1'b0;

      // independence: alternate which gate is high
      for (int i = 0; i < 4; i++) begin
         bus.en    = (i % 2 == 0);
         bus.start = (i % 2 == 1);
         bus.d_en  = 2'(i + 1);
         bus.d_st  = 32'hA000_0000 + 32'(i);
         step();
         check_all("indep");
      end

      // a low gate must keep its register even with unknown data
      bus.en = 1'b0; bus.start = 1'b0;
      bus.d_en = 'x; bus.d_st = 'x;
      step();
      check_all("x_hold");

      // randomized traffic, occasional reset held over an edge or pulsed between edges
      for (int i = 0; i < 400; i++) begin
         bus.en    = 1'($urandom_range(0, 1));
         bus.start = 1'($urandom_range(0, 1));
         bus.d_en  = 2'($urandom);
         bus.d_st  = $urandom;
         sbus.en   = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 24) == 0);
         step();
         check_all("rand");
         if ($urandom_range(0, 29) == 0) pulse_reset("rand_pulse");
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
